mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: E-stage mult/div-class instruction valid this cycle; qualifies mdop.
REQ-004 SHALL have port mdop, input, 3 bits: operation code; 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
REQ-005 SHALL have port mdsrc_a, input, 32 bits: rs operand (dividend / multiplicand / mthi-mtlo data).
REQ-006 SHALL have port mdsrc_b, input, 32 bits: rt operand (divisor / multiplier).
REQ-007 SHALL have port buzy, output, 1 bit: unit occupied; consumed by the hazard stage for stalling.
REQ-008 SHALL have port hi, output, 32 bits: HI register contents, driven directly from the register.
REQ-009 SHALL have port lo, output, 32 bits: LO register contents, driven directly from the register.
REQ-010 SHALL use parameter MULT_CYC, default 5: buzy length for mult/multu.
REQ-011 SHALL use parameter DIV_CYC, default 10: buzy length for div/divu.

Function
REQ-012 SHALL implement a 2-state FSM: IDLE (buzy=0) and BUSY (buzy=1), with a 4-bit down-counter.
REQ-013 In IDLE, when start=1 and mdop is 1-4: compute the result combinationally, latch it into pending HI/LO registers, load the counter with MULT_CYC or DIV_CYC, and enter BUSY at the same edge.
REQ-014 buzy SHALL be high for exactly N consecutive cycles, starting the cycle after the start cycle (N = MULT_CYC or DIV_CYC).
REQ-015 In BUSY, the counter SHALL decrement each cycle.
REQ-016 At the edge ending the last BUSY cycle, hi/lo SHALL load the pending values and the FSM SHALL return to IDLE.
REQ-017 New hi/lo values SHALL be visible in the first cycle with buzy=0.
REQ-018 mult SHALL form the signed 64-bit product; multu SHALL form the unsigned 64-bit product. hi = bits 63:32, lo = bits 31:0.
REQ-019 div/divu SHALL write lo = quotient and hi = remainder.
REQ-020 Signed div SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-022 Divide by zero (div or divu) SHALL still hold buzy for DIV_CYC cycles, then leave hi/lo unchanged.
REQ-023 In IDLE, start=1 with mdop=5 SHALL write hi=mdsrc_a at that edge (or mdop=6 writes lo=mdsrc_a); buzy stays 0.
REQ-024 start with mdop 0 or 7 SHALL be ignored.
REQ-025 start while in BUSY (any mdop, including 5/6) SHALL be ignored: no counter restart, no hi/lo write.
REQ-026 On the edge where BUSY ends while start=1 arrives, the completion write SHALL take effect and start SHALL be ignored.
REQ-027 Pending registers SHALL never be observable on the hi/lo outputs before completion.

Reset
REQ-028 reset=1 at a clock edge SHALL force hi=0, lo=0, buzy=0, state IDLE, counter=0, pending=0; reset SHALL take priority over all other inputs.
REQ-029 Reset during BUSY SHALL abort the operation: the pending result is discarded and never written afterwards.

Verification
REQ-030 mult: a=0xFFFFFFFF, b=0x00000002, start at cycle 0 -> buzy=1 in cycles 1-5; cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFFE, buzy=0.
REQ-031 multu with the same operands -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 div: a=0xFFFFFFF9 (-7), b=2 -> buzy=1 for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu: a=7, b=2 -> lo=3, hi=1.
REQ-033 mthi 0x12, then div a=5, b=0 -> buzy for 10 cycles; afterwards hi=0x12 and lo unchanged.
REQ-034 Start mult (a=3, b=4), assert reset in busy cycle 3 -> next cycle buzy=0, hi=lo=0; they remain 0 through cycle 10.
REQ-035 During a divu busy period, issue mtlo 0xAA and mult start -> both ignored; the divu result appears at the normal completion cycle, and buzy is not extended.

Source files
------------

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: result is computed at issue and held in pending registers.
// hi/lo are updated only after a fixed busy window, so stalls are driven by buzy alone.
module mult_div_unit #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] mdsrc_a,
  input  logic [31:0] mdsrc_b,
  output logic        buzy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYC);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;
  logic [31:0]        div_b;
  logic               div_zero;
  logic               div_ovf;
  logic               is_md;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_wr;
  logic [3:0]         res_n;

  always_comb begin
    div_zero = (mdsrc_b == 32'd0);
    // Substitute a harmless divisor on divide-by-zero; the result is discarded anyway.
    div_b    = div_zero ? 32'd1 : mdsrc_b;
    div_ovf  = (mdsrc_a == 32'h8000_0000) && (mdsrc_b == 32'hFFFF_FFFF);
    prod_s   = $signed(mdsrc_a) * $signed(mdsrc_b);
    prod_u   = {32'd0, mdsrc_a} * {32'd0, mdsrc_b};
    quo_s    = div_ovf ? 32'sh8000_0000 : $signed(mdsrc_a) / $signed(div_b);
    rem_s    = div_ovf ? 32'sd0 : $signed(mdsrc_a) % $signed(div_b);
    quo_u    = mdsrc_a / div_b;
    rem_u    = mdsrc_a % div_b;

    is_md  = 1'b0;
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    res_n  = DIV_N;
    case (mdop)
      3'd1: begin is_md = 1'b1; res_wr = 1'b1; res_n = MULT_N;
                  res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      3'd2: begin is_md = 1'b1; res_wr = 1'b1; res_n = MULT_N;
                  res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      3'd3: begin is_md = 1'b1; res_wr = !div_zero;
                  res_hi = rem_s; res_lo = quo_s; end
      3'd4: begin is_md = 1'b1; res_wr = !div_zero;
                  res_hi = rem_u; res_lo = quo_u; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      buzy    <= 1'b0;
      cnt     <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && is_md) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            cnt     <= res_n;
            state   <= BUSY;
            buzy    <= 1'b1;
          end else if (start && mdop == 3'd5) begin
            hi <= mdsrc_a;
          end else if (start && mdop == 3'd6) begin
            lo <= mdsrc_a;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          // start is deliberately not looked at here, including on the completion edge.
          if (cnt == 4'd1) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            state <= IDLE;
            buzy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
